// File: rtl/jtag_pkg.sv
// Shared JTAG constants: IR select encodings and data-register lengths,
// used by the DR chain and the IR decoder alike.
package jtag_pkg;

    typedef enum logic [1:0] {
        SEL_BYPASS = 2'b00,
        SEL_IDCODE = 2'b01,
        SEL_USER   = 2'b10,
        SEL_DBG    = 2'b11
    } dr_sel_e;

    localparam int MAX_DR_W    = 40;
    localparam int CNT_W       = 7;
    localparam int DBG_LEN_MIN = 33;
    localparam int DBG_LEN_MAX = 40;

    localparam logic [CNT_W-1:0] CNT_MAX    = 7'd127;
    localparam logic [CNT_W-1:0] LEN_BYPASS = 7'd1;
    localparam logic [CNT_W-1:0] LEN_IDCODE = 7'd32;
    localparam logic [CNT_W-1:0] LEN_USER   = 7'd32;

    // DBG length is a per-instance parameter, so the caller supplies it.
    function automatic logic [CNT_W-1:0] dr_len(input dr_sel_e sel,
                                                input logic [CNT_W-1:0] dbg_len);
        logic [CNT_W-1:0] len;
        len = LEN_BYPASS;
        case (sel)
            SEL_BYPASS: len = LEN_BYPASS;
            SEL_IDCODE: len = LEN_IDCODE;
            SEL_USER:   len = LEN_USER;
            SEL_DBG:    len = dbg_len;
            default:    len = LEN_BYPASS;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/jtag_dr_chain_if.sv
// Signal bundle between the TAP controller side and the DR chain.
interface jtag_dr_chain_if;
    import jtag_pkg::*;

    logic                  shiftDR;
    logic                  tdi;
    logic [1:0]            ir_sel;
    logic [MAX_DR_W-1:0]   capture_data;
    logic                  dr_tdo;
    logic [MAX_DR_W-1:0]   dr_value;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  len_match;
    logic                  over_shift;
    logic [1:0]            cur_sel;

    modport master (
        output shiftDR, tdi, ir_sel, capture_data,
        input  dr_tdo, dr_value, bit_cnt, len_match, over_shift, cur_sel
    );

    modport slave (
        input  shiftDR, tdi, ir_sel, capture_data,
        output dr_tdo, dr_value, bit_cnt, len_match, over_shift, cur_sel
    );

endinterface

// File: rtl/jtag_dr_len_cnt.sv
// Latched DR select, active length lookup, shift counter and over-shift flag.
module jtag_dr_len_cnt
    import jtag_pkg::*;
#(
    parameter int DBG_LEN = 40
) (
    input  logic             clockDR,
    input  logic             trst_n,
    input  logic             shift,
    input  logic [1:0]       ir_sel,
    output logic [1:0]       cur_sel,
    output logic [CNT_W-1:0] active_len,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             len_match,
    output logic             over_shift
);

    localparam logic [CNT_W-1:0] DBG_LEN_C = CNT_W'(DBG_LEN);

    // Length follows the select latched at capture, never the live IR.
    assign active_len = dr_len(dr_sel_e'(cur_sel), DBG_LEN_C);
    assign len_match  = (bit_cnt == active_len);

    always_ff @(posedge clockDR or negedge trst_n) begin
        if (!trst_n) begin
            cur_sel    <= SEL_BYPASS;
            bit_cnt    <= '0;
            over_shift <= 1'b0;
        end else if (shift) begin
            if (bit_cnt != CNT_MAX) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (bit_cnt >= active_len) begin
                over_shift <= 1'b1;
            end
        end else begin
            cur_sel    <= ir_sel;
            bit_cnt    <= '0;
            over_shift <= 1'b0;
        end
    end

endmodule

// File: rtl/jtag_dr_chain.sv
// JTAG data-register chain: BYPASS, IDCODE, USER and DBG registers sharing
// one right-justified shift register, with shift-count bookkeeping.
module jtag_dr_chain
    import jtag_pkg::*;
#(
    parameter logic [31:0] IDCODE_VAL = 32'h1A2B_3C4D,
    parameter int          DBG_LEN    = 40
) (
    input  logic          clockDR,
    input  logic          trst_n,
    jtag_dr_chain_if.slave bus
);

    if (IDCODE_VAL[0] != 1'b1) begin : g_bad_idcode
        $error("jtag_dr_chain: IDCODE_VAL bit 0 must be 1");
    end
    if (DBG_LEN < DBG_LEN_MIN || DBG_LEN > DBG_LEN_MAX) begin : g_bad_dbg_len
        $error("jtag_dr_chain: DBG_LEN out of range 33..40");
    end

    logic [MAX_DR_W-1:0] sr;
    logic [MAX_DR_W-1:0] shifted;
    logic [MAX_DR_W-1:0] shift_val;
    logic [MAX_DR_W-1:0] capture_val;
    logic [MAX_DR_W-1:0] dbg_cap;
    logic [1:0]          cur_sel;
    logic [CNT_W-1:0]    active_len;
    logic [CNT_W-1:0]    bit_cnt;
    logic                len_match;
    logic                over_shift;
    logic                unused_cap_lsbs;

    jtag_dr_len_cnt #(
        .DBG_LEN (DBG_LEN)
    ) u_len_cnt (
        .clockDR    (clockDR),
        .trst_n     (trst_n),
        .shift      (bus.shiftDR),
        .ir_sel     (bus.ir_sel),
        .cur_sel    (cur_sel),
        .active_len (active_len),
        .bit_cnt    (bit_cnt),
        .len_match  (len_match),
        .over_shift (over_shift)
    );

    // DBG status bits reflect the frame that is just ending.
    always_comb begin
        dbg_cap = '0;
        for (int i = 2; i < MAX_DR_W; i++) begin
            if (i < DBG_LEN) begin
                dbg_cap[i] = bus.capture_data[i];
            end
        end
        dbg_cap[1] = over_shift;
        dbg_cap[0] = len_match;
    end

    always_comb begin
        capture_val = '0;
        case (dr_sel_e'(bus.ir_sel))
            SEL_BYPASS: capture_val = '0;
            SEL_IDCODE: capture_val = {{(MAX_DR_W-32){1'b0}}, IDCODE_VAL};
            SEL_USER:   capture_val = {{(MAX_DR_W-32){1'b0}}, bus.capture_data[31:0]};
            SEL_DBG:    capture_val = dbg_cap;
            default:    capture_val = '0;
        endcase
    end

    // tdi enters at bit L-1; everything at or above L is forced to zero.
    always_comb begin
        shifted   = {1'b0, sr[MAX_DR_W-1:1]};
        shift_val = '0;
        for (int i = 0; i < MAX_DR_W; i++) begin
            if (i == int'(active_len) - 1) begin
                shift_val[i] = bus.tdi;
            end else if (i < int'(active_len) - 1) begin
                shift_val[i] = shifted[i];
            end
        end
    end

    always_ff @(posedge clockDR or negedge trst_n) begin
        if (!trst_n) begin
            sr <= '0;
        end else if (bus.shiftDR) begin
            sr <= shift_val;
        end else begin
            sr <= capture_val;
        end
    end

    assign unused_cap_lsbs = ^bus.capture_data[1:0];

    assign bus.dr_tdo     = sr[0];
    assign bus.dr_value   = sr;
    assign bus.bit_cnt    = bit_cnt;
    assign bus.len_match  = len_match;
    assign bus.over_shift = over_shift;
    assign bus.cur_sel    = cur_sel;

endmodule

// File: tb/tb_jtag_dr_chain.sv
// Self-checking bench for jtag_dr_chain: queue-based register model, directed
// frames with literal expectations, then randomized frames with resets.
module tb_jtag_dr_chain;
    import jtag_pkg::*;

    localparam logic [31:0] IDCODE  = 32'h1A2B_3C4D;
    localparam int          DBG_LEN = 40;

    logic clockDR = 1'b0;
    logic trst_n  = 1'b0;

    jtag_dr_chain_if bus();

    jtag_dr_chain #(
        .IDCODE_VAL (IDCODE),
        .DBG_LEN    (DBG_LEN)
    ) dut (
        .clockDR (clockDR),
        .trst_n  (trst_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model: the active register is a bit queue, LSB (tdo end) at index 0.
    int m_sel;
    bit m_q[$];
    int m_n;
    bit m_over;

    function automatic int len_of(input int s);
        case (s)
            0:       return 1;
            1:       return 32;
            2:       return 32;
            default: return DBG_LEN;
        endcase
    endfunction

    function automatic int m_cnt();
        return (m_n > 127) ? 127 : m_n;
    endfunction

    function automatic bit m_match();
        return m_cnt() == len_of(m_sel);
    endfunction

    function automatic logic [63:0] m_value();
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < m_q.size(); i++) v[i] = m_q[i];
        return v;
    endfunction

    task automatic model_reset();
        m_sel = 0;
        m_q.delete();
        m_q.push_back(1'b0);
        m_n    = 0;
        m_over = 1'b0;
    endtask

    task automatic model_capture(input int sel, input logic [39:0] cap);
        bit          po;
        bit          pm;
        logic [63:0] v;
        po = m_over;
        pm = m_match();
        case (sel)
            0:       v = 64'd0;
            1:       v = 64'(IDCODE);
            2:       v = 64'(cap[31:0]);
            default: begin
                v    = 64'(cap) & ((64'd1 << DBG_LEN) - 64'd1);
                v[1] = po;
                v[0] = pm;
            end
        endcase
        m_sel = sel;
        m_q.delete();
        for (int i = 0; i < len_of(sel); i++) m_q.push_back(v[i]);
        m_n    = 0;
        m_over = 1'b0;
    endtask

    task automatic model_shift(input bit t);
        bit dropped;
        if (m_n >= len_of(m_sel)) m_over = 1'b1;
        dropped = m_q.pop_front();
        m_q.push_back(t);
        m_n++;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("dr_tdo",     64'(bus.dr_tdo),     64'(m_q[0]));
        chk("dr_value",   64'(bus.dr_value),   m_value());
        chk("bit_cnt",    64'(bus.bit_cnt),    64'(m_cnt()));
        chk("len_match",  64'(bus.len_match),  64'(m_match()));
        chk("over_shift", 64'(bus.over_shift), 64'(m_over));
        chk("cur_sel",    64'(bus.cur_sel),    64'(m_sel));
    endtask

    always @(posedge clockDR) begin
        #2;
        compare_all();
    end

    task automatic edge_clk(input bit shift, input bit t);
        bus.shiftDR = shift;
        bus.tdi     = t;
        #2;
        if (shift) model_shift(t);
        else       model_capture(int'(bus.ir_sel), bus.capture_data);
        clockDR = 1'b1;
        #5;
        clockDR = 1'b0;
        #3;
    endtask

    task automatic capture(input logic [1:0] sel, input logic [39:0] cap);
        bus.ir_sel       = sel;
        bus.capture_data = cap;
        edge_clk(1'b0, 1'b0);
    endtask

    task automatic pulse_reset();
        trst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        #2;
        trst_n = 1'b1;
        #2;
    endtask

    function automatic logic [39:0] rand40();
        return {8'($urandom), 32'($urandom)};
    endfunction

    initial begin
        logic [31:0] got;
        logic [31:0] d;
        logic        t0;
        logic        t1;
        int          n;
        int          rst_at;

        bus.shiftDR      = 1'b0;
        bus.tdi          = 1'b0;
        bus.ir_sel       = 2'b00;
        bus.capture_data = '0;
        model_reset();
        #5;
        chk("rst_tdo",   64'(bus.dr_tdo),     64'd0);
        chk("rst_value", 64'(bus.dr_value),   64'd0);
        chk("rst_cnt",   64'(bus.bit_cnt),    64'd0);
        chk("rst_match", 64'(bus.len_match),  64'd0);
        chk("rst_over",  64'(bus.over_shift), 64'd0);
        chk("rst_sel",   64'(bus.cur_sel),    64'd0);
        trst_n = 1'b1;
        #5;

        // IDCODE shifted out LSB first
        capture(2'b01, 40'd0);
        got = '0;
        for (int i = 0; i < 32; i++) begin
            got[i] = bus.dr_tdo;
            edge_clk(1'b1, 1'b0);
        end
        chk("idcode_seq",   64'(got),            64'h1A2B_3C4D);
        chk("idcode_first4", 64'(got[3:0]),      64'hD);
        chk("idcode_match", 64'(bus.len_match),  64'd1);
        chk("idcode_over",  64'(bus.over_shift), 64'd0);

        // BYPASS: one-bit delay, second shift overflows
        capture(2'b00, rand40());
        t0 = bus.dr_tdo;
        edge_clk(1'b1, 1'b1);
        t1 = bus.dr_tdo;
        edge_clk(1'b1, 1'b0);
        chk("bypass_tdo", 64'({t1, t0}),        64'b10);
        chk("bypass_cnt", 64'(bus.bit_cnt),     64'd2);
        chk("bypass_over", 64'(bus.over_shift), 64'd1);

        // USER register round trip
        capture(2'b10, 40'hAB_DEAD_BEEF);
        d = 32'h0000_0005;
        for (int i = 0; i < 32; i++) begin
            got[i] = bus.dr_tdo;
            edge_clk(1'b1, d[i]);
        end
        chk("user_out",   64'(got),          64'hDEAD_BEEF);
        chk("user_value", 64'(bus.dr_value), 64'h5);

        // DBG overshift reported in the next DBG capture
        capture(2'b11, rand40());
        for (int i = 0; i < 41; i++) edge_clk(1'b1, 1'($urandom));
        capture(2'b11, 40'hFF_FFFF_FFFC);
        chk("dbg_status", 64'(bus.dr_value[1:0]), 64'b10);
        chk("dbg_value",  64'(bus.dr_value),      64'hFF_FFFF_FFFE);

        // ir_sel change mid-frame is ignored
        capture(2'b01, 40'd0);
        for (int i = 0; i < 10; i++) edge_clk(1'b1, 1'($urandom));
        bus.ir_sel = 2'b10;
        for (int i = 0; i < 22; i++) edge_clk(1'b1, 1'($urandom));
        chk("sticky_sel",   64'(bus.cur_sel),   64'd1);
        chk("sticky_cnt",   64'(bus.bit_cnt),   64'd32);
        chk("sticky_match", 64'(bus.len_match), 64'd1);

        // Reset mid USER frame, then long BYPASS shift saturates the counter
        capture(2'b10, rand40());
        for (int i = 0; i < 10; i++) edge_clk(1'b1, 1'($urandom));
        trst_n = 1'b0;
        #1;
        model_reset();
        chk("trst_tdo",   64'(bus.dr_tdo),     64'd0);
        chk("trst_value", 64'(bus.dr_value),   64'd0);
        chk("trst_cnt",   64'(bus.bit_cnt),    64'd0);
        chk("trst_match", 64'(bus.len_match),  64'd0);
        chk("trst_over",  64'(bus.over_shift), 64'd0);
        chk("trst_sel",   64'(bus.cur_sel),    64'd0);
        #2;
        trst_n = 1'b1;
        #2;
        for (int i = 0; i < 130; i++) edge_clk(1'b1, 1'($urandom));
        chk("sat_cnt",  64'(bus.bit_cnt),    64'd127);
        chk("sat_over", 64'(bus.over_shift), 64'd1);
        chk("sat_sel",  64'(bus.cur_sel),    64'd0);

        // Randomized frames with idle gaps, stray ir_sel changes and resets
        for (int f = 0; f < 60; f++) begin
            capture(2'($urandom), rand40());
            n      = int'($urandom_range(0, 50));
            rst_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 50)) : -1;
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 5) == 0) bus.ir_sel = 2'($urandom);
                if ($urandom_range(0, 9) == 0) begin
                    #20;
                    compare_all();
                end
                if (k == rst_at) pulse_reset();
                edge_clk(1'b1, 1'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jtag_dr_chain.md
JTAG_DR_CHAIN -- requirements
Module: jtag_dr_chain

Interface
REQ-001 SHALL have parameter IDCODE_VAL, default 32'h1A2B_3C4D; IDCODE capture value; bit 0 SHALL be 1 (elaboration check).
REQ-002 SHALL have parameter DBG_LEN, default 40; debug command register length; legal range 33..40.
REQ-003 clockDR  input  1  DR clock from the TAP; gated, rising edges only in Capture-DR/Shift-DR.
REQ-004 trst_n  input  1  reset; asynchronous, active-low.
REQ-005 shiftDR  input  1  1 = shift edge, 0 = capture edge; sampled at clockDR rise.
REQ-006 tdi  input  1  serial data in.
REQ-007 ir_sel  input  2  DR select: 00 BYPASS (len 1), 01 IDCODE (32), 10 USER (32), 11 DBG (DBG_LEN).
REQ-008 capture_data  input  40  parallel capture value for USER (bits 31:0) and DBG (bits DBG_LEN-1:2).
REQ-009 dr_tdo  output  1  serial out = bit 0 of active register.
REQ-010 dr_value  output  40  active shift register contents, right-justified, unused upper bits 0.
REQ-011 bit_cnt  output  7  shift edges since last capture, saturating at 127.
REQ-012 len_match  output  1  bit_cnt equals active length.
REQ-013 over_shift  output  1  sticky: a shift occurred with bit_cnt >= active length since last capture.
REQ-014 cur_sel  output  2  ir_sel latched at last capture.

Function
REQ-015 Capture edge (shiftDR=0): cur_sel<=ir_sel; bit_cnt<=0; over_shift<=0; register loaded per REQ-016..019.
REQ-016 BYPASS capture SHALL load 1'b0.
REQ-017 IDCODE capture SHALL load IDCODE_VAL.
REQ-018 USER capture SHALL load capture_data[31:0].
REQ-019 DBG capture SHALL load {capture_data[DBG_LEN-1:2], prev_over, prev_match}, prev_* = over_shift and len_match values immediately before this edge.
REQ-020 Shift edge (shiftDR=1): register of length L SHALL shift right one bit; bit L-1 <= tdi; bits >= L remain 0.
REQ-021 Shift edge SHALL increment bit_cnt by 1, holding at 127 once reached.
REQ-022 Shift edge with bit_cnt >= L before the edge SHALL set over_shift; shifting continues normally (bits wrap through tdi as usual).
REQ-023 len_match SHALL be combinational from bit_cnt and cur_sel's length.
REQ-024 ir_sel changes between captures SHALL be ignored; length, tdo source, and shift behaviour follow cur_sel only.
REQ-025 dr_tdo SHALL be combinational from register bit 0; valid after each clockDR rise, before the next falling edge of the TAP clock.
REQ-026 No clockDR edges (TAP idle/pause) SHALL leave all state unchanged.
REQ-027 Latency: capture/shift effects visible on outputs after the same clockDR rising edge; no pipeline stages.

Reset
REQ-028 trst_n low SHALL asynchronously force register=0, bit_cnt=0, over_shift=0, cur_sel=2'b00 (BYPASS); dr_tdo=0, len_match=0.
REQ-029 Reset asserted mid-shift SHALL discard the partial frame; the first edge after release SHALL be treated per shiftDR (a shift edge into BYPASS is legal).

Structure
REQ-030 ir_sel encodings and per-register lengths SHALL be constants in shared package jtag_pkg, used also by the IR decoder.
REQ-031 Length lookup and bit_cnt/over_shift logic SHALL be in sub-module jtag_dr_len_cnt; data path in top.

Verification
REQ-032 Reset, ir_sel=01, capture, 32 shifts tdi=0 -> dr_tdo sequence = IDCODE_VAL LSB first (1,0,1,1,0,0,1,0...), len_match=1, over_shift=0.
REQ-033 ir_sel=00, capture, shift tdi=1 then 0 -> dr_tdo 0 then 1; bit_cnt=2; over_shift=1 after second shift.
REQ-034 ir_sel=10, capture_data=32'hDEAD_BEEF, 32 shifts tdi=32'h0000_0005 LSB first -> dr_tdo out = DEADBEEF LSB first, dr_value=32'h0000_0005.
REQ-035 DBG frame with 41 shifts, then DBG capture with capture_data=40'hFF_FFFF_FFFC -> dr_value[1:0]=2'b10 (prev_over=1, prev_match=0).
REQ-036 Capture with ir_sel=01, switch ir_sel=10 mid-shift -> cur_sel stays 01, len_match at bit_cnt=32.
REQ-037 trst_n pulse after 10 USER shifts -> all outputs 0, cur_sel=00; 130 BYPASS shifts -> bit_cnt=127.
